// File: rtl/stonyman_adc_responder.sv
// Emulated Stonyman serial pixel ADC: answers cs_n/sclk conversion frames
// with 8-bit pattern pixels shifted out MSB first.
module stonyman_adc_responder #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned LEAD_ZEROS = 2,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned COLS       = 112,
  parameter int unsigned ROWS       = 112
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        sclk,
  output logic        sdata,
  output logic        sdata_oe,
  input  logic [1:0]  pattern_mode,
  input  logic [7:0]  pattern_seed,
  input  logic        restart,
  output logic        conv_done,
  output logic        short_frame,
  output logic        frame_wrap,
  output logic [15:0] conv_count
);

  localparam int unsigned TAIL_BITS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int unsigned CNT_W     = $clog2(FRAME_BITS + 1);
  localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

  state_t                r_state;
  logic                  r_cs_s, r_cs_q, r_sclk_s, r_sclk_q;
  logic [FRAME_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [15:0]           r_index;

  logic                  w_cs_fall, w_cs_rise, w_sclk_fall, w_last, w_advance;
  logic                  w_col_wrap, w_row_wrap;
  logic [7:0]            w_pixel;
  logic [FRAME_BITS-1:0] w_load;
  logic [7:0]            w_index_hi_unused;

  // Inputs pass one sync stage, then the previous value is kept for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_s   <= 1'b1;
      r_cs_q   <= 1'b1;
      r_sclk_s <= 1'b1;
      r_sclk_q <= 1'b1;
    end else begin
      r_cs_s   <= cs_n;
      r_cs_q   <= r_cs_s;
      r_sclk_s <= sclk;
      r_sclk_q <= r_sclk_s;
    end
  end

  assign w_cs_fall   = r_cs_q & ~r_cs_s;
  assign w_cs_rise   = ~r_cs_q & r_cs_s;
  assign w_sclk_fall = r_sclk_q & ~r_sclk_s;
  assign w_last      = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_advance   = (r_state == S_SHIFT) && !w_cs_rise && w_sclk_fall && w_last;
  assign w_col_wrap  = (r_col == COL_W'(COLS - 1));
  assign w_row_wrap  = (r_row == ROW_W'(ROWS - 1));
  assign w_index_hi_unused = r_index[15:8];

  always_comb begin
    w_pixel = pattern_seed;
    case (pattern_mode)
      2'd0:    w_pixel = pattern_seed;
      2'd1:    w_pixel = pattern_seed + r_index[7:0];
      2'd2:    w_pixel = r_index[0] ? ~pattern_seed : pattern_seed;
      default: w_pixel = pattern_seed + 8'(r_row) + 8'(r_col);
    endcase
  end

  assign w_load = FRAME_BITS'(DATA_BITS'(w_pixel)) << TAIL_BITS;

  // Shifter is zero outside a frame, so its MSB is the line value directly
  assign sdata = r_shreg[FRAME_BITS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      sdata_oe    <= 1'b0;
      conv_done   <= 1'b0;
      short_frame <= 1'b0;
      conv_count  <= 16'd0;
    end else begin
      conv_done   <= 1'b0;
      short_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_shreg   <= w_load;
            r_bit_cnt <= '0;
            sdata_oe  <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            r_shreg     <= '0;
            sdata_oe    <= 1'b0;
            short_frame <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_sclk_fall) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_shreg   <= r_shreg << 1;
            if (w_last) begin
              conv_done  <= 1'b1;
              conv_count <= conv_count + 16'd1;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_cs_rise) begin
            r_shreg  <= '0;
            sdata_oe <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pixel position; restart takes priority over an advance in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_index    <= 16'd0;
      r_col      <= '0;
      r_row      <= '0;
      frame_wrap <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      if (restart) begin
        r_index <= 16'd0;
        r_col   <= '0;
        r_row   <= '0;
      end else if (w_advance) begin
        r_index <= r_index + 16'd1;
        if (w_col_wrap) begin
          r_col <= '0;
          if (w_row_wrap) begin
            r_row      <= '0;
            frame_wrap <= 1'b1;
          end else begin
            r_row <= r_row + ROW_W'(1);
          end
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stonyman_adc_responder.sv
// Directed bench for stonyman_adc_responder acting as controller peer.
module tb_stonyman_adc_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b1;
  logic        sdata, sdata_oe;
  logic [1:0]  pattern_mode = 2'd0;
  logic [7:0]  pattern_seed = 8'd0;
  logic        restart = 1'b0;
  logic        conv_done, short_frame, frame_wrap;
  logic [15:0] conv_count;

  int total = 0;
  int bad = 0;
  int n_done = 0, n_short = 0, n_wrap = 0;
  int base_done, base_short, base_wrap;
  logic [15:0] bits;

  stonyman_adc_responder #(
    .DATA_BITS(8), .LEAD_ZEROS(2), .FRAME_BITS(16), .COLS(5), .ROWS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .sclk(sclk),
    .sdata(sdata), .sdata_oe(sdata_oe),
    .pattern_mode(pattern_mode), .pattern_seed(pattern_seed),
    .restart(restart), .conv_done(conv_done), .short_frame(short_frame),
    .frame_wrap(frame_wrap), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_done === 1'b1)   n_done++;
    if (short_frame === 1'b1) n_short++;
    if (frame_wrap === 1'b1)  n_wrap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop cs_n, sample the first bit, then give nfalls sclk periods (3 low, 3 high)
  task automatic run_frame(input int nfalls, output logic [15:0] b);
    b = '0;
    @(posedge clk); #1 cs_n = 1'b0;
    cycles(3);
    b[15] = sdata;
    for (int i = 1; i <= nfalls; i++) begin
      sclk = 1'b0;
      cycles(3);
      if (i < 16) b[15-i] = sdata;
      sclk = 1'b1;
      cycles(3);
    end
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    cycles(3);
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic full_frame(output logic [7:0] pix);
    logic [15:0] b;
    run_frame(16, b);
    end_frame();
    pix = b[13:6];
  endtask

  logic [7:0] pix;

  initial begin
    // Reset values
    cycles(3);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_oe", 32'(sdata_oe), 32'd0);
    check("rst_done", 32'(conv_done), 32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    check("rst_wrap", 32'(frame_wrap), 32'd0);
    check("rst_count", 32'(conv_count), 32'd0);
    reset_n = 1'b1;
    cycles(2);

    // Constant 0xA5: full frame bit pattern, oe timing on cs_n rise
    pattern_mode = 2'd0; pattern_seed = 8'hA5;
    base_done = n_done;
    run_frame(16, bits);
    check("const_bits", 32'(bits), 32'h2940);
    check("const_oe_hold", 32'(sdata_oe), 32'd1);
    check("const_sdata_hold", 32'(sdata), 32'd0);
    cs_n = 1'b1;
    cycles(1);
    check("const_oe_1edge", 32'(sdata_oe), 32'd1);
    cycles(1);
    check("const_oe_2edge", 32'(sdata_oe), 32'd0);
    cycles(2);
    check("const_done_pulses", 32'(n_done - base_done), 32'd1);
    check("const_count", 32'(conv_count), 32'd1);

    // Ramp 0xFE, mod-256 wrap
    pattern_mode = 2'd1; pattern_seed = 8'hFE;
    pulse_restart();
    full_frame(pix); check("ramp_0", 32'(pix), 32'hFE);
    full_frame(pix); check("ramp_1", 32'(pix), 32'hFF);
    full_frame(pix); check("ramp_2", 32'(pix), 32'h00);
    full_frame(pix); check("ramp_3", 32'(pix), 32'h01);
    check("ramp_count", 32'(conv_count), 32'd5);

    // Short frame after 9 falls: no count, pixel repeats
    base_short = n_short; base_done = n_done;
    run_frame(9, bits);
    check("short_pix", 32'(bits[13:6]), 32'h02);
    end_frame();
    check("short_pulse", 32'(n_short - base_short), 32'd1);
    check("short_no_done", 32'(n_done - base_done), 32'd0);
    check("short_count", 32'(conv_count), 32'd5);
    check("short_oe", 32'(sdata_oe), 32'd0);
    full_frame(pix); check("short_repeat_pix", 32'(pix), 32'h02);
    check("short_repeat_count", 32'(conv_count), 32'd6);

    // Checker 0x0F with restart after frame 3
    pattern_mode = 2'd2; pattern_seed = 8'h0F;
    pulse_restart();
    full_frame(pix); check("chk_0", 32'(pix), 32'h0F);
    full_frame(pix); check("chk_1", 32'(pix), 32'hF0);
    full_frame(pix); check("chk_2", 32'(pix), 32'h0F);
    pulse_restart();
    full_frame(pix); check("chk_restart", 32'(pix), 32'h0F);
    check("chk_count", 32'(conv_count), 32'd10);

    // Gradient seed 0 on a 3x5 array: one wrap after 15 frames
    pattern_mode = 2'd3; pattern_seed = 8'h00;
    pulse_restart();
    base_wrap = n_wrap;
    for (int k = 0; k < 15; k++) begin
      full_frame(pix);
      check("grad_pix", 32'(pix), 32'((k / 5) + (k % 5)));
      if (k == 13) check("grad_no_wrap_yet", 32'(n_wrap - base_wrap), 32'd0);
    end
    check("grad_wrap_once", 32'(n_wrap - base_wrap), 32'd1);
    full_frame(pix); check("grad_after_wrap", 32'(pix), 32'h00);
    check("grad_wrap_total", 32'(n_wrap - base_wrap), 32'd1);
    check("grad_count", 32'(conv_count), 32'd26);

    // Async reset after 5 falls: immediate reset values, no pulses
    pattern_mode = 2'd1; pattern_seed = 8'h10;
    base_done = n_done; base_short = n_short;
    run_frame(5, bits);
    check("mid_oe_before", 32'(sdata_oe), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(sdata_oe), 32'd0);
    check("mid_rst_sdata", 32'(sdata), 32'd0);
    check("mid_rst_count", 32'(conv_count), 32'd0);
    cs_n = 1'b1; sclk = 1'b1;
    cycles(3);
    check("mid_rst_no_done", 32'(n_done - base_done), 32'd0);
    check("mid_rst_no_short", 32'(n_short - base_short), 32'd0);
    reset_n = 1'b1;
    cycles(2);
    full_frame(pix); check("post_rst_pix", 32'(pix), 32'h10);
    check("post_rst_count", 32'(conv_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stonyman_adc_responder.md
# stonyman_adc_responder

Synthesizable emulator of the serial pixel ADC behind each Stonyman camera: the responding end of the `cs_n`/`sclk`/`sdata` link driven by `adc_controller`. It detects conversion frames started by the controller and shifts out 8-bit pixel values from an internal pattern generator, MSB first. It stands in for the physical ADC in bring-up bitstreams and serves as the reference peer for controller regression benches.

## Interface
Parameters:
- `DATA_BITS`, 8: pixel width carried in each frame.
- `LEAD_ZEROS`, 2: zero bits shifted before the data.
- `FRAME_BITS`, 16: `sclk` falling edges per conversion; trailing bits are zero.
- `COLS`, 112: pixel columns per frame (gradient mode).
- `ROWS`, 112: pixel rows per frame (gradient mode).

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs_n` in 1: chip select from the controller, synchronous to `clk`.
- `sclk` in 1: serial clock from the controller, synchronous to `clk`.
- `sdata` out 1: serial data to the controller.
- `sdata_oe` out 1: high while `sdata` is driven (pad tristate control).
- `pattern_mode` in 2: 0 constant, 1 ramp, 2 checker, 3 gradient.
- `pattern_seed` in 8: base value for all modes.
- `restart` in 1: synchronous pulse that clears the pixel index, row, and column.
- `conv_done` out 1: one-cycle pulse when a full frame completes.
- `short_frame` out 1: one-cycle pulse when `cs_n` rises before `FRAME_BITS` falling edges.
- `frame_wrap` out 1: one-cycle pulse when row/col wrap from (ROWS-1, COLS-1) to (0,0).
- `conv_count` out 16: completed conversions, wrapping modulo 2^16.

## Operation
- Edge detection: `cs_q` and `sclk_q` register the previous `cs_n` and `sclk`. A `cs_n` fall is `cs_q & ~cs_n`; a `cs_n` rise is `~cs_q & cs_n`; an `sclk` fall is `sclk_q & ~sclk`.
- FSM states:
  - IDLE, reached from reset or any `cs_n` rise.
  - SHIFT.
  - HOLD, reached after `FRAME_BITS` falls while `cs_n` is low.
- IDLE -> SHIFT on a `cs_n` fall:
  - Load `shreg = {LEAD_ZEROS zeros, pixel, FRAME_BITS-LEAD_ZEROS-DATA_BITS zeros}`.
  - `sdata = shreg[MSB]`, `sdata_oe = 1`, `bit_cnt = 0`.
- SHIFT, on each `sclk` fall:
  - `bit_cnt++` and shift left.
  - `sdata` takes the next bit.
  - On the `FRAME_BITS`-th fall: go to HOLD, `sdata = 0`, pulse `conv_done`, `conv_count++`, advance the pixel index.
- HOLD keeps `sdata = 0` and `sdata_oe = 1` until the `cs_n` rise, then goes to IDLE.
- A `cs_n` rise in SHIFT:
  - Go to IDLE and pulse `short_frame`.
  - Do not advance the pixel index or `conv_count`.
- IDLE: `sdata = 0`, `sdata_oe = 0`. `sclk` edges are ignored.
- Pixel value is computed combinationally and captured only on a `cs_n` fall. Changes to `pattern_mode` or `pattern_seed` during a frame take effect on the next frame. All arithmetic is mod 256.
  - Constant: `seed`.
  - Ramp: `seed + index[7:0]`.
  - Checker: `seed` when `index[0] == 0`, otherwise `~seed`.
  - Gradient: `seed + row + col`.
- Pixel index:
  - `col` counts 0..COLS-1. At wrap, `row` increments; `row` counts 0..ROWS-1.
  - The (ROWS-1, COLS-1) -> (0,0) transition pulses `frame_wrap` in the same cycle as `conv_done`.
  - `index` is a 16-bit linear counter that wraps, and is cleared with row/col.
- `restart` clears index, row, and col next cycle and does not abort a frame in progress.
  - If `restart` coincides with an index advance, `restart` wins: the counters end at 0 and `frame_wrap` is not pulsed.

## Timing
- Reset values: `sdata=0`, `sdata_oe=0`, `conv_done=0`, `short_frame=0`, `frame_wrap=0`, `conv_count=0`, state IDLE. `cs_q` and `sclk_q` reset to 1.
- Latency:
  - `sdata` and `sdata_oe` update 2 `clk` rising edges after the `cs_n` fall is presented. That is one edge to register `cs_q`, detect on the next.
  - The same 2-edge latency applies after each `sclk` fall.
- Constraints on the controller:
  - `sclk` high and low phases must each be ≥3 `clk` cycles for the controller to sample stable data on the rising `sclk`.
  - The first `sclk` fall must come ≥2 cycles after `cs_n` fall.
- Simultaneous `cs_n` rise and `sclk` fall: the rise wins.
  - If the fall would have been the `FRAME_BITS`-th, the frame still counts as short.
- A `cs_n` fall in the same cycle as a rise cannot occur on a single-bit signal. Back-to-back frames need ≥1 cycle of `cs_n` high.
- Asserting `reset_n` mid-frame forces all reset values immediately; the aborted frame produces no pulses.

## Test plan
- Constant mode, seed 0xA5, one 16-edge frame:
  - Sampled bits must be 00 10100101 000000.
  - `conv_done` pulses once, `conv_count` = 1, `sdata_oe` drops 2 cycles after the `cs_n` rise.
- Ramp mode, seed 0xFE, 4 frames -> pixels 0xFE, 0xFF, 0x00, 0x01; `conv_count` = 4.
- Gradient mode, seed 0, COLS=ROWS=112, 12544 frames:
  - Pixel at (row 1, col 111) = 112.
  - `frame_wrap` pulses exactly once, on frame 12544; the next pixel = 0.
- `cs_n` rises after 9 `sclk` falls:
  - `short_frame` pulses, `conv_count` is unchanged.
  - The next full frame repeats the same pixel.
- Checker mode, seed 0x0F, with `restart` pulsed after frame 3 -> pixels 0x0F, 0xF0, 0x0F, then 0x0F again.
- `reset_n` low after 5 `sclk` falls:
  - All outputs go to reset values asynchronously, with no `conv_done` or `short_frame` pulse.
  - After release, the first full frame yields pixel index 0.
